tach_speed_meter: RTL and testbench

TACH_SPEED_METER -- requirements
Module: tach_speed_meter

---
 rtl/tach_speed_meter_if.sv | 12 +
 rtl/tach_speed_meter.sv | 92 +++++++++
 tb/tb_tach_speed_meter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tach_speed_meter_if.sv
// Fan tachometer meter signal bundle: control and tach inputs, measurement results out.
interface tach_speed_meter_if;
   logic       en_i;
   logic       clk_en_i;
   logic       tach_i;
   logic [7:0] speed_o;
   logic       valid_o;
   logic       stall_o;

   modport master (output en_i, clk_en_i, tach_i, input speed_o, valid_o, stall_o);
   modport slave  (input en_i, clk_en_i, tach_i, output speed_o, valid_o, stall_o);
endinterface

// File: rtl/tach_speed_meter.sv
// Fan tachometer speed meter: synchronize and debounce tach, count falling edges per
// gate window of clk_en_i ticks, publish a saturated count plus a stall flag.
module tach_speed_meter #(
   parameter int DEBOUNCE_CYCLES = 15,
   parameter int GATE_TICKS      = 10,
   parameter int STALL_WINDOWS   = 3
) (
   input logic               clk,
   input logic               rst_n,
   tach_speed_meter_if.slave bus
);
   localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] GATE_LAST = 8'(GATE_TICKS - 1);
   localparam logic [3:0] STALL_TH  = 4'(STALL_WINDOWS);

   logic       sync1, sync2, tach_f;
   logic [3:0] deb_cnt;
   logic [7:0] tick_cnt, pulse_cnt, speed_q;
   logic [3:0] stall_cnt;
   logic       stall_q, valid_q;
   logic       differ, accept, pulse_ev, win_end;
   logic [7:0] pulse_nxt;
   logic [3:0] stall_nxt;

   // Synchronizer ignores en_i so the debouncer sees a settled level on re-enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= bus.tach_i;
         sync2 <= sync1;
      end
   end

   always_comb begin
      differ    = sync2 ^ tach_f;
      accept    = bus.en_i & differ & (deb_cnt == DEB_LAST);
      pulse_ev  = accept & tach_f;
      win_end   = bus.en_i & bus.clk_en_i & (tick_cnt == GATE_LAST);
      pulse_nxt = pulse_cnt;
      if (pulse_ev && (pulse_cnt != 8'hFF)) pulse_nxt = pulse_cnt + 8'd1;
      stall_nxt = 4'd0;
      if (pulse_nxt == 8'd0) stall_nxt = (stall_cnt == 4'hF) ? stall_cnt : stall_cnt + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tach_f  <= 1'b1;
         deb_cnt <= 4'd0;
      end else if (!bus.en_i || !differ) begin
         deb_cnt <= 4'd0;
      end else if (accept) begin
         tach_f  <= sync2;
         deb_cnt <= 4'd0;
      end else begin
         deb_cnt <= deb_cnt + 4'd1;
      end
   end

   // Window-end cycle folds its own pulse event into the result via pulse_nxt.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt  <= 8'd0;
         pulse_cnt <= 8'd0;
         speed_q   <= 8'd0;
         stall_cnt <= 4'd0;
         stall_q   <= 1'b0;
         valid_q   <= 1'b0;
      end else if (!bus.en_i) begin
         tick_cnt  <= 8'd0;
         pulse_cnt <= 8'd0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= win_end;
         if (win_end) begin
            tick_cnt  <= 8'd0;
            pulse_cnt <= 8'd0;
            speed_q   <= pulse_nxt;
            stall_cnt <= stall_nxt;
            stall_q   <= (stall_nxt >= STALL_TH);
         end else begin
            pulse_cnt <= pulse_nxt;
            if (bus.clk_en_i) tick_cnt <= tick_cnt + 8'd1;
         end
      end
   end

   assign bus.speed_o = speed_q;
   assign bus.valid_o = valid_q;
   assign bus.stall_o = stall_q;
endmodule

// File: tb/tb_tach_speed_meter.sv
// Randomized and directed bench for tach_speed_meter against a window-level reference model.
module tb_tach_speed_meter;
   localparam int DEB = 3;
   localparam int GT  = 4;
   localparam int SW  = 2;

   logic clk = 1'b0;
   logic rst_n;
   tach_speed_meter_if tif ();

   tach_speed_meter #(.DEBOUNCE_CYCLES(DEB), .GATE_TICKS(GT), .STALL_WINDOWS(SW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (tif.slave)
   );

   always #50 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: filtered level flips once the last DEB synchronized samples, all taken
   // while enabled, disagree with it; windows collect falling flips and report min(n,255).
   bit m_s1, m_s2, m_f;
   bit dq_v[$];
   bit dq_q[$];
   int m_tick, m_pc, m_zeros, m_speed;
   bit m_valid, m_stall;

   task automatic model_step();
      bit acc, ev;
      if (!rst_n) begin
         m_s1 = 1; m_s2 = 1; m_f = 1;
         dq_v.delete(); dq_q.delete();
         m_tick = 0; m_pc = 0; m_zeros = 0; m_speed = 0;
         m_valid = 0; m_stall = 0;
         return;
      end
      dq_v.push_back(m_s2);
      dq_q.push_back(tif.en_i);
      if (dq_v.size() > DEB) begin
         void'(dq_v.pop_front());
         void'(dq_q.pop_front());
      end
      acc = (dq_v.size() == DEB);
      for (int i = 0; i < dq_v.size(); i++)
         if (!dq_q[i] || dq_v[i] == m_f) acc = 0;
      ev = acc && m_f;
      if (acc) m_f = ~m_f;
      m_s2 = m_s1;
      m_s1 = tif.tach_i;
      m_valid = 0;
      if (!tif.en_i) begin
         m_tick = 0; m_pc = 0;
      end else begin
         if (ev) m_pc++;
         if (tif.clk_en_i) begin
            if (m_tick == GT - 1) begin
               m_speed = (m_pc > 255) ? 255 : m_pc;
               m_valid = 1;
               m_zeros = (m_pc == 0) ? m_zeros + 1 : 0;
               m_stall = (m_zeros >= SW);
               m_pc = 0; m_tick = 0;
            end else m_tick++;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic c, input logic t);
      rst_n = r; tif.en_i = e; tif.clk_en_i = c; tif.tach_i = t;
      @(posedge clk);
      model_step();
      #1;
      chk("valid", tif.valid_o, m_valid);
      chk("speed", tif.speed_o, m_speed);
      chk("stall", tif.stall_o, m_stall);
   endtask

   // Periodic tach (lo low cycles then hi high) with a gate tick every ce_per cycles.
   task automatic run(input int n, input int ce_per, input int lo, input int hi);
      for (int i = 0; i < n; i++)
         cyc(1, 1, (i % ce_per) == ce_per - 1, (i % (lo + hi)) >= lo);
   endtask

   initial begin
      int vcnt, rl;
      logic en, tk;
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
      chk("rst_speed", tif.speed_o, 0);
      chk("rst_valid", tif.valid_o, 0);
      chk("rst_stall", tif.stall_o, 0);

      run(2 * 20 * GT, 20, 8, 8);
      chk("clean5_speed", tif.speed_o, 5);
      chk("clean5_valid", tif.valid_o, 1);

      run(2 * 20 * GT, 20, 2, 6);
      chk("glitch_speed", tif.speed_o, 0);
      chk("stall_set", tif.stall_o, 1);

      run(20 * GT, 20, 8, 72);
      chk("stall_clr_speed", tif.speed_o, 1);
      chk("stall_clr", tif.stall_o, 0);

      run(2 * 20 * GT, 20, 3, 5);
      chk("low3_speed", tif.speed_o, 10);

      run(2 * 500 * GT, 500, 3, 3);
      chk("sat_speed", tif.speed_o, 255);

      run(50, 20, 8, 8);
      cyc(0, 1, 0, 1);
      chk("midrst_speed", tif.speed_o, 0);
      chk("midrst_stall", tif.stall_o, 0);
      cyc(1, 1, 0, 1);
      chk("midrst_novalid", tif.valid_o, 0);
      run(20 * GT - 1, 20, 8, 32);
      cyc(1, 1, 1, 1);
      chk("post_rst_speed", tif.speed_o, 2);

      // Accept edge lands exactly on the window-end edge (sample + 2 sync + DEB-1).
      for (int i = 0; i < 2 * 20 * GT; i++) begin
         cyc(1, 1, (i % 20) == 19, !(i >= 75 && i < 83));
         if (i == 79) chk("edge_at_end", tif.speed_o, 1);
      end
      chk("edge_next_win", tif.speed_o, 0);

      run(20 * GT, 20, 8, 32);
      vcnt = 0;
      for (int i = 0; i < 20 * GT; i++) begin
         cyc(1, 0, (i % 20) == 19, (i % 40) >= 8);
         if (tif.valid_o) vcnt++;
      end
      chk("en_low_valid", vcnt, 0);
      chk("en_low_hold", tif.speed_o, 2);
      run(20 * GT, 20, 8, 32);
      chk("en_back_speed", tif.speed_o, 2);

      en = 1; tk = 1; rl = 4;
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(149) == 0) en = ~en;
         if (rl == 0) begin
            tk = ~tk;
            rl = ($urandom_range(9) == 0) ? $urandom_range(60, 20) : $urandom_range(6, 1);
         end
         rl--;
         cyc($urandom_range(499) != 0, en, $urandom_range(7) == 0, tk);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
